mat_mult_ctrl: RTL and testbench

Top-level sequencer that computes C = A x B (A is MxK, B is KxN) from two synchronous-read matrix memories. It walks every output element (i,j) in row-major order and, for each, runs K read/multiply/accumulate steps. It then writes the accumulated result to a C memory port. It is the controller layer above the single-product MAC datapath, owning the address counters, read enables, accumulator and completion handshake.

---
 rtl/mat_mult_pkg.sv | 23 ++
 rtl/mat_mult_idx_counter.sv | 73 +++++++
 rtl/mat_mult_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mat_mult_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// Shared types and width helpers for the matrix-multiply controller and its index counter.
package mat_mult_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        MAC  = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Address width for a dimension; a dimension of 1 still gets a 1-bit bus.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Accumulator width that holds K full-width products without overflow.
    function automatic int result_w(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

endpackage

// File: rtl/mat_mult_idx_counter.sv
// Nested i/j/k element counters; next values are exposed so the controller can register
// read addresses on the same edge the counters advance.
module mat_mult_idx_counter
    import mat_mult_pkg::*;
#(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   inc_k,
    input  logic                   inc_ij,
    output logic [addr_w(M)-1:0]   i,
    output logic [addr_w(N)-1:0]   j,
    output logic [addr_w(M)-1:0]   i_nxt,
    output logic [addr_w(N)-1:0]   j_nxt,
    output logic [addr_w(K)-1:0]   k_nxt,
    output logic                   last_k,
    output logic                   last_elem
);

    localparam int IW = addr_w(M);
    localparam int KW = addr_w(K);
    localparam int JW = addr_w(N);

    logic [KW-1:0] k;
    logic          last_i;
    logic          last_j;

    assign last_i    = (i == IW'(M - 1));
    assign last_j    = (j == JW'(N - 1));
    assign last_k    = (k == KW'(K - 1));
    assign last_elem = last_i && last_j;

    always_comb begin
        i_nxt = i;
        j_nxt = j;
        k_nxt = k;
        if (clear) begin
            i_nxt = '0;
            j_nxt = '0;
            k_nxt = '0;
        end else begin
            if (inc_k) begin
                k_nxt = last_k ? '0 : k + KW'(1);
            end
            // Row-major walk: j is the fast index, i wraps back to 0 after the last row.
            if (inc_ij) begin
                if (!last_j) begin
                    j_nxt = j + JW'(1);
                end else begin
                    j_nxt = '0;
                    i_nxt = last_i ? '0 : i + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            i <= i_nxt;
            j <= j_nxt;
            k <= k_nxt;
        end
    end

endmodule

// File: rtl/mat_mult_ctrl.sv
// Sequencer computing C = A x B from synchronous-read memories: per element, K rounds of
// read / wait / multiply-accumulate, then one C write strobe.
module mat_mult_ctrl
    import mat_mult_pkg::*;
#(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = result_w(DATA_WIDTH_INIT_MATRIX, K)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
    output logic                                  matrix_a_re,
    output logic [addr_w(M)-1:0]                  row_addr_a,
    output logic [addr_w(K)-1:0]                  col_addr_a,
    output logic                                  matrix_b_re,
    output logic [addr_w(K)-1:0]                  row_addr_b,
    output logic [addr_w(N)-1:0]                  col_addr_b,
    output logic                                  matrix_c_we,
    output logic [addr_w(M)-1:0]                  row_addr_c,
    output logic [addr_w(N)-1:0]                  col_addr_c,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]   data_out_c,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic                                  busy,
    output logic                                  done,
    output state_t                                state_dbg
);

    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int PW = 2 * DW;
    localparam int IW = addr_w(M);
    localparam int KW = addr_w(K);
    localparam int JW = addr_w(N);

    typedef logic [DW-1:0] elem_t;
    typedef logic [RW-1:0] result_t;

    state_t        state;
    result_t       acc;
    result_t       acc_sum;
    logic          c_we_q;
    logic          cnt_clear;
    logic          inc_k;
    logic          inc_ij;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [IW-1:0] i_nxt;
    logic [JW-1:0] j_nxt;
    logic [KW-1:0] k_nxt;
    logic          last_k;
    logic          last_elem;
    elem_t         a_word;
    elem_t         b_word;

    assign a_word    = data_in_a;
    assign b_word    = data_in_b;
    assign acc_sum   = acc + RW'(product_reg);
    assign state_dbg = state;

    assign cnt_clear = (state == IDLE) || abort;
    assign inc_k     = (state == MAC);
    assign inc_ij    = (state == WB);

    // An abort landing on a WB cycle must suppress that cycle's write, so the strobe is gated live.
    assign matrix_c_we = c_we_q && !abort;

    mat_mult_idx_counter #(
        .M (M),
        .K (K),
        .N (N)
    ) u_idx (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (cnt_clear),
        .inc_k     (inc_k),
        .inc_ij    (inc_ij),
        .i         (i),
        .j         (j),
        .i_nxt     (i_nxt),
        .j_nxt     (j_nxt),
        .k_nxt     (k_nxt),
        .last_k    (last_k),
        .last_elem (last_elem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            acc         <= '0;
            product_reg <= '0;
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            c_we_q      <= 1'b0;
            row_addr_a  <= '0;
            col_addr_a  <= '0;
            row_addr_b  <= '0;
            col_addr_b  <= '0;
            row_addr_c  <= '0;
            col_addr_c  <= '0;
            data_out_c  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            c_we_q      <= 1'b0;
            done        <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                acc   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state       <= RD;
                            acc         <= '0;
                            busy        <= 1'b1;
                            matrix_a_re <= 1'b1;
                            matrix_b_re <= 1'b1;
                            row_addr_a  <= i_nxt;
                            col_addr_a  <= k_nxt;
                            row_addr_b  <= k_nxt;
                            col_addr_b  <= j_nxt;
                        end
                    end
                    RD: state <= WT;
                    WT: begin
                        product_reg <= PW'(a_word) * PW'(b_word);
                        state       <= MAC;
                    end
                    MAC: begin
                        acc <= acc_sum;
                        if (last_k) begin
                            state      <= WB;
                            c_we_q     <= 1'b1;
                            row_addr_c <= i;
                            col_addr_c <= j;
                            data_out_c <= acc_sum;
                        end else begin
                            state       <= RD;
                            matrix_a_re <= 1'b1;
                            matrix_b_re <= 1'b1;
                            row_addr_a  <= i_nxt;
                            col_addr_a  <= k_nxt;
                            row_addr_b  <= k_nxt;
                            col_addr_b  <= j_nxt;
                        end
                    end
                    WB: begin
                        acc <= '0;
                        if (last_elem) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= RD;
                            matrix_a_re <= 1'b1;
                            matrix_b_re <= 1'b1;
                            row_addr_a  <= i_nxt;
                            col_addr_a  <= k_nxt;
                            row_addr_b  <= k_nxt;
                            col_addr_b  <= j_nxt;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Directed bench for mat_mult_ctrl: 1-cycle-latency A/B memories, C writes checked
// against a reference-model queue.
module tb_mat_mult_ctrl;
    import mat_mult_pkg::*;

    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 2 * DW + $clog2(K);
    localparam int EW = 2 + 2 + RW;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [DW-1:0]   data_in_a;
    logic [DW-1:0]   data_in_b;
    logic            matrix_a_re, matrix_b_re, matrix_c_we;
    logic [1:0]      row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
    logic [RW-1:0]   data_out_c;
    logic [2*DW-1:0] product_reg;
    logic            busy, done;
    state_t          state_dbg;

    logic [DW-1:0]   mem_a [4][4];
    logic [DW-1:0]   mem_b [4][4];
    logic [RW-1:0]   cmem  [4][4];
    logic [EW-1:0]   exp_q [$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              wr_cnt = 0;
    int              done_cnt = 0;

    wire [146:0] all_outs = {matrix_a_re, row_addr_a, col_addr_a, matrix_b_re, row_addr_b,
                             col_addr_b, matrix_c_we, row_addr_c, col_addr_c, data_out_c,
                             product_reg, busy, done};

    mat_mult_ctrl #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .data_in_a   (data_in_a),
        .data_in_b   (data_in_b),
        .matrix_a_re (matrix_a_re),
        .row_addr_a  (row_addr_a),
        .col_addr_a  (col_addr_a),
        .matrix_b_re (matrix_b_re),
        .row_addr_b  (row_addr_b),
        .col_addr_b  (col_addr_b),
        .matrix_c_we (matrix_c_we),
        .row_addr_c  (row_addr_c),
        .col_addr_c  (col_addr_c),
        .data_out_c  (data_out_c),
        .product_reg (product_reg),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // clock / memories
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (matrix_a_re) data_in_a <= mem_a[row_addr_a][col_addr_a];
        if (matrix_b_re) data_in_b <= mem_b[row_addr_b][col_addr_b];
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] model_c(input int i, input int j);
        logic [RW-1:0] s = '0;
        for (int k = 0; k < K; k++) s += RW'(mem_a[i][k]) * RW'(mem_b[k][j]);
        return s;
    endfunction

    // scoreboard: every C write pops one expected {row, col, data}
    always @(negedge clk) begin
        if (resetn && matrix_c_we) begin
            logic [EW-1:0] e;
            wr_cnt++;
            cmem[row_addr_c][col_addr_c] = data_out_c;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'bx}};
            check("c_write", {row_addr_c, col_addr_c, data_out_c}, e);
        end
        if (resetn && done) done_cnt++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_demo();
        int a_init [4][4] = '{'{6,2,5,2}, '{6,2,6,1}, '{2,4,5,2}, '{7,2,5,1}};
        int b_init [4][4] = '{'{1,1,4,4}, '{1,7,2,1}, '{3,2,1,1}, '{2,1,6,6}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem_a[r][c] = DW'(a_init[r][c]);
                mem_b[r][c] = DW'(b_init[r][c]);
            end
    endtask

    task automatic load_ones();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem_a[r][c] = '1;
                mem_b[r][c] = '1;
            end
    endtask

    task automatic push_all();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                exp_q.push_back({2'(i), 2'(j), model_c(i, j)});
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic run_full(input string tag);
        int n, wr0, dn0;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        push_all();
        start_pulse();
        wait_done(n);
        check({tag, "_done_latency"}, n, 209);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_writes"}, wr_cnt - wr0, 16);
        check({tag, "_done_pulses"}, done_cnt - dn0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, wr0, dn0;
        bit found;

        // reset with start held high
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) tick();
        check("reset_outs", all_outs, 0);
        check("reset_state", state_dbg, IDLE);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", {state_dbg, busy, all_outs}, {IDLE, 1'b0, 147'd0});

        // functional run on the demo matrices
        load_demo();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_rd", {busy, matrix_a_re, matrix_b_re}, 3'b111);
        push_all();
        wait_done(n);
        check("demo_done_latency", n, 209);
        tick();
        check("demo_done_one_cycle", done, 0);
        check("demo_writes", wr_cnt, 16);
        check("demo_done_pulses", done_cnt, 1);
        check("c00", cmem[0][0], 27);
        check("c01", cmem[0][1], 32);
        check("c02", cmem[0][2], 45);
        check("c03", cmem[0][3], 43);
        check("c10", cmem[1][0], 28);

        // widest operands
        load_ones();
        run_full("ones");
        check("ones_c33", cmem[3][3], 66'h3_FFFF_FFF8_0000_0004);
        check("ones_c00", cmem[0][0], 66'h3_FFFF_FFF8_0000_0004);

        // abort on the WB of element (0,1)
        load_demo();
        wr0 = wr_cnt;
        dn0 = done_cnt;
        exp_q.push_back({2'd0, 2'd0, model_c(0, 0)});
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (state_dbg == WB && row_addr_c == 2'd0 && col_addr_c == 2'd1) found = 1'b1;
        end
        check("abort_found_wb", found, 1);
        abort = 1'b1;
        #2;
        check("abort_we_low", matrix_c_we, 0);
        tick();
        abort = 1'b0;
        check("abort_idle", {state_dbg, busy}, {IDLE, 1'b0});
        repeat (5) tick();
        check("abort_no_done", done_cnt - dn0, 0);
        check("abort_writes", wr_cnt - wr0, 1);
        run_full("after_abort");

        // start held high for the whole run, including DONE
        wr0 = wr_cnt;
        dn0 = done_cnt;
        push_all();
        start = 1'b1;
        tick();
        wait_done(n);
        check("spam_done_latency", n, 209);
        tick();
        start = 1'b0;
        check("spam_idle", {state_dbg, busy, done}, {IDLE, 2'b00});
        repeat (3) tick();
        check("spam_still_idle", state_dbg, IDLE);
        check("spam_writes", wr_cnt - wr0, 16);
        check("spam_done_pulses", done_cnt - dn0, 1);

        // start with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {state_dbg, busy, matrix_a_re}, {IDLE, 2'b00});

        // async reset inside a MAC state
        wr0 = wr_cnt;
        push_all();
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick();
            if (state_dbg == MAC && wr_cnt - wr0 >= 2) found = 1'b1;
        end
        check("rst_found_mac", found, 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_outs", all_outs, 0);
        check("rst_mid_state", state_dbg, IDLE);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        run_full("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
